// File: rtl/sccb_config_sequencer_if.sv
// Bus bundle between the SCCB configurator and its table ROM / camera pins.
// The master side is the sequencer; the slave side is the ROM, pad ring and system control.
interface sccb_config_sequencer_if;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sioc;
    logic        siod_out;
    logic        siod_oe;
    logic        busy;
    logic        done;

    modport master (
        input  start, rom_data,
        output rom_addr, sioc, siod_out, siod_oe, busy, done
    );

    modport slave (
        output start, rom_data,
        input  rom_addr, sioc, siod_out, siod_oe, busy, done
    );
endinterface

// File: rtl/sccb_config_sequencer.sv
// OV7670 boot-time configurator: walks a {reg,value} ROM table and issues 3-phase SCCB writes.
// Build macro SCCB_CFG_DELAY_EN enables the 16'hFFF0 delay entry (WAIT state).
module sccb_config_sequencer #(
    parameter int unsigned CLK_HZ    = 25_000_000,
    parameter int unsigned SCCB_HZ   = 100_000,
    parameter int unsigned DIV       = CLK_HZ / (4 * SCCB_HZ),
    parameter logic [7:0]  DEVICE_ID = 8'h42
`ifdef SCCB_CFG_DELAY_EN
   ,parameter int unsigned DELAY_CYCLES = 250_000
`endif
) (
    input logic                     clk,
    input logic                     rst_n,
    sccb_config_sequencer_if.master bus
);
    localparam int DIV_W = $clog2(DIV);
    localparam logic [15:0] ENTRY_END = 16'hFFFF;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_FINISH
`ifdef SCCB_CFG_DELAY_EN
       ,S_WAIT
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [2:0]         qtr_q, qtr_d;
    logic [4:0]         bit_q, bit_d;
    logic [26:0]        shift_q, shift_d;
    logic [7:0]         rom_addr_q, rom_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sioc_q, sioc_d;
    logic               siod_q, siod_d;
    logic               oe_q, oe_d;
    logic               tick;

`ifdef SCCB_CFG_DELAY_EN
    localparam int WAIT_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
`endif

    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d    = state_q;
        div_cnt_d  = '0;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        sioc_d     = 1'b1;
        siod_d     = 1'b1;
        oe_d       = 1'b1;
`ifdef SCCB_CFG_DELAY_EN
        wait_cnt_d = '0;
`endif

        // Quarter divider runs only while a bus phase is being timed.
        if (state_q inside {S_START, S_BITS, S_STOP, S_GAP}) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                qtr_d = '0;
                bit_d = '0;
                if (bus.rom_data == ENTRY_END) begin
                    state_d = S_FINISH;
`ifdef SCCB_CFG_DELAY_EN
                end else if (bus.rom_data == ENTRY_DELAY) begin
                    state_d = S_WAIT;
`endif
                end else begin
                    shift_d = {DEVICE_ID, 1'b0, bus.rom_data[15:8], 1'b0,
                               bus.rom_data[7:0], 1'b0};
                    state_d = S_START;
                end
            end
            S_START: begin
                sioc_d = (qtr_q == 3'd0);
                siod_d = 1'b0;
                if (tick) begin
                    if (qtr_q == 3'd1) begin
                        qtr_d   = '0;
                        state_d = S_BITS;
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
            end
            S_BITS: begin
                // Slots 9/18/27 belong to the camera, so SIOD is released there.
                sioc_d = (qtr_q == 3'd1) || (qtr_q == 3'd2);
                siod_d = shift_q[26];
                oe_d   = !((bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26));
                if (tick) begin
                    if (qtr_q == 3'd3) begin
                        qtr_d   = '0;
                        shift_d = {shift_q[25:0], 1'b0};
                        if (bit_q == 5'd26) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                sioc_d = (qtr_q != 3'd0);
                siod_d = (qtr_q == 3'd2);
                if (tick) begin
                    if (qtr_q == 3'd2) begin
                        qtr_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (qtr_q == 3'd7) begin
                        qtr_d      = '0;
                        rom_addr_d = rom_addr_q + 8'd1;
                        state_d    = S_FETCH;
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
            end
`ifdef SCCB_CFG_DELAY_EN
            S_WAIT: begin
                if (wait_cnt_q == WAIT_W'(DELAY_CYCLES - 1)) begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    state_d    = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
`endif
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: pin drivers are flops with async reset so an abort idles the bus in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sioc_q     <= 1'b1;
            siod_q     <= 1'b1;
            oe_q       <= 1'b1;
`ifdef SCCB_CFG_DELAY_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sioc_q     <= sioc_d;
            siod_q     <= siod_d;
            oe_q       <= oe_d;
`ifdef SCCB_CFG_DELAY_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sioc     = sioc_q;
    assign bus.siod_out = siod_q;
    assign bus.siod_oe  = oe_q;
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Self-checking bench for sccb_config_sequencer: table vectors, corner sequences and random
// tables checked against a transaction-level model (bytes on the wire, cycles to done).
module tb_sccb_config_sequencer;
    localparam int          TB_DIV   = 2;
    localparam int          TB_DELAY = 100;
    localparam logic [7:0]  TB_ID    = 8'h42;
    localparam logic [26:0] OE_MASK  = 27'h7FFFFFF & ~((27'd1 << 18) | (27'd1 << 9) | 27'd1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    sccb_config_sequencer_if bus();

`ifdef SCCB_CFG_DELAY_EN
    sccb_config_sequencer #(.DIV(TB_DIV), .DEVICE_ID(TB_ID), .DELAY_CYCLES(TB_DELAY)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master));
`else
    sccb_config_sequencer #(.DIV(TB_DIV), .DEVICE_ID(TB_ID)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data valid one cycle after the address changes.
    logic [15:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: decodes start/stop conditions and bits sampled at SIOC rise.
    logic        p_sioc = 1'b1, p_siod = 1'b1, p_done = 1'b0;
    bit          in_frame = 1'b0;
    logic [1:0]  cur_bits[$];
    logic [26:0] fr_data[$], fr_oe[$];
    int          fr_len[$];
    int          sioc_rises = 0;
    int          done_cyc = -1;
    logic [26:0] mon_d, mon_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            cur_bits.delete();
        end else begin
            if (bus.sioc && !p_sioc) begin
                sioc_rises++;
                if (in_frame) cur_bits.push_back({bus.siod_oe, bus.siod_out});
            end
            if (bus.sioc && p_sioc && p_siod && !bus.siod_out) begin
                in_frame = 1'b1;
                cur_bits.delete();
            end
            if (bus.sioc && p_sioc && !p_siod && bus.siod_out && in_frame) begin
                mon_d = '0;
                mon_m = '0;
                for (int i = 0; i < 27 && i < cur_bits.size(); i++) begin
                    mon_d = {mon_d[25:0], cur_bits[i][0]};
                    mon_m = {mon_m[25:0], cur_bits[i][1]};
                end
                fr_data.push_back(mon_d);
                fr_oe.push_back(mon_m);
                fr_len.push_back(cur_bits.size());
                in_frame = 1'b0;
            end
            if (bus.done && !p_done) done_cyc = cyc;
        end
        p_sioc = bus.sioc;
        p_siod = bus.siod_out;
        p_done = bus.done;
    end

    // Expected transaction list for the current run.
    logic [23:0] exp_q[$];
    int          exp_lat;
    int          exp_term;

    // Reference model: each ordinary entry is one 121-quarter write plus fetch/decode,
    // a delay entry costs fetch/decode plus the delay, the terminator costs 3 cycles to done.
    task automatic model_rom();
        exp_q.delete();
        exp_lat  = 0;
        exp_term = 0;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_lat += 3;
                exp_term = a;
                break;
            end
`ifdef SCCB_CFG_DELAY_EN
            if (rom[a] == 16'hFFF0) begin
                exp_lat += 2 + TB_DELAY;
                continue;
            end
`endif
            exp_q.push_back({TB_ID, rom[a]});
            exp_lat += 2 + 121 * TB_DIV;
        end
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input bit mid_start);
        int t0;
        int k;
        fr_data.delete();
        fr_oe.delete();
        fr_len.delete();
        sioc_rises = 0;
        done_cyc   = -1;
        pulse_start(t0);
        check({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
        check({tag, "_done_clr"}, 64'(bus.done), 64'd0);
        check({tag, "_addr0"}, 64'(bus.rom_addr), 64'd0);
        if (mid_start) begin
            repeat (60) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        for (k = 0; k < 20000 && !bus.done; k++) @(negedge clk);
        #1;
        check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        check({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
        check({tag, "_latency"}, 64'(done_cyc - t0), 64'(exp_lat));
        check({tag, "_term_addr"}, 64'(bus.rom_addr), 64'(exp_term));
        check({tag, "_nwrites"}, 64'(fr_data.size()), 64'(exp_q.size()));
        for (int f = 0; f < fr_data.size() && f < exp_q.size(); f++) begin
            check($sformatf("%s_w%0d_bytes", tag, f),
                  64'({fr_data[f][26:19], fr_data[f][17:10], fr_data[f][8:1]}), 64'(exp_q[f]));
            check($sformatf("%s_w%0d_oe", tag, f), 64'(fr_oe[f]), 64'(OE_MASK));
            check($sformatf("%s_w%0d_nrise", tag, f), 64'(fr_len[f]), 64'd28);
        end
        if (exp_q.size() == 0) check({tag, "_no_sioc"}, 64'(sioc_rises), 64'd0);
        repeat (5) @(negedge clk);
        check({tag, "_done_held"}, 64'(bus.done), 64'd1);
    endtask

    typedef struct {
        logic [63:0] tbl;
        int          n_ent;
        logic [47:0] exp_w;
        int          exp_writes;
        int          exp_lat;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int t0;
        int k;
        bus.start    = 1'b0;
        bus.rom_data = '0;
        clear_rom();

        vecs[0] = '{tbl: {16'h1280, 16'hFFFF, 32'hFFFFFFFF}, n_ent: 2,
                    exp_w: {24'h421280, 24'h0}, exp_writes: 1, exp_lat: 247};
        vecs[1] = '{tbl: {16'hFFFF, 48'hFFFFFFFFFFFF}, n_ent: 1,
                    exp_w: 48'h0, exp_writes: 0, exp_lat: 3};
`ifdef SCCB_CFG_DELAY_EN
        vecs[2] = '{tbl: {16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF}, n_ent: 3,
                    exp_w: {24'h421100, 24'h0}, exp_writes: 1, exp_lat: 349};
`else
        vecs[2] = '{tbl: {16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF}, n_ent: 3,
                    exp_w: {24'h42FFF0, 24'h421100}, exp_writes: 2, exp_lat: 491};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sioc", 64'(bus.sioc), 64'd1);
        check("rst_siod", 64'(bus.siod_out), 64'd1);
        check("rst_oe", 64'(bus.siod_oe), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_addr", 64'(bus.rom_addr), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven vectors with hand-derived expectations
        for (int v = 0; v < 3; v++) begin
            clear_rom();
            for (int i = 0; i < vecs[v].n_ent; i++) rom[i] = vecs[v].tbl[63 - 16 * i -: 16];
            exp_q.delete();
            for (int w = 0; w < vecs[v].exp_writes; w++) exp_q.push_back(vecs[v].exp_w[47 - 24 * w -: 24]);
            exp_lat  = vecs[v].exp_lat;
            exp_term = vecs[v].n_ent - 1;
            run_and_check($sformatf("vec%0d", v), 1'b0);
        end

        // start pulsed mid-transfer is ignored
        clear_rom();
        rom[0] = 16'h1280;
        model_rom();
        run_and_check("midstart", 1'b1);

        // Async reset during BITS q1 of the first bit, then a clean restart from entry 0
        clear_rom();
        rom[0] = 16'h1280;
        pulse_start(t0);
        for (k = 0; k < 200 && bus.sioc; k++) @(negedge clk);
        for (k = 0; k < 200 && !bus.sioc; k++) @(negedge clk);
        check("prerst_siod", 64'(bus.siod_out), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sioc", 64'(bus.sioc), 64'd1);
        check("midrst_siod", 64'(bus.siod_out), 64'd1);
        check("midrst_oe", 64'(bus.siod_oe), 64'd1);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        model_rom();
        run_and_check("postrst", 1'b0);

        // Random tables against the reference model
        for (int r = 0; r < 5; r++) begin
            int n;
            clear_rom();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                logic [15:0] e;
                e = 16'($urandom);
                if (e == 16'hFFFF) e = 16'h0000;
                rom[i] = e;
            end
            model_rom();
            run_and_check($sformatf("rnd%0d", r), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sccb_config_sequencer.md
# sccb_config_sequencer

Boot-time OV7670 register configurator.
- Walks an external register table of 16-bit {reg, value} entries.
- Issues each entry as a 3-phase SCCB write (ID 0x42, reg, value) on SIOC/SIOD.
- Raises `done` when the table terminator is reached.
- Sits beside the pixel capture path and must finish before capture data is trusted.

## Interface
Parameters:
- `CLK_HZ`, 25_000_000: system clock frequency.
- `SCCB_HZ`, 100_000: SIOC rate.
- `DIV`, CLK_HZ/(4*SCCB_HZ): clocks per quarter-bit phase; valid range ≥2.
- `DEVICE_ID`, 8'h42: SCCB write address byte.
- `DELAY_CYCLES`, 250_000: wait length for a delay entry (macro builds only).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: 1-cycle pulse; begins the sequence from entry 0.
- `rom_addr` out 8: table index.
- `rom_data` in 16: table entry, {reg[15:8], value[7:0]}; valid 1 cycle after `rom_addr` changes (synchronous ROM).
- `sioc` out 1: SCCB clock.
- `siod_out` out 1: SIOD drive value.
- `siod_oe` out 1: SIOD output enable; 0 = released (tri-state at top level).
- `busy` out 1: sequence in progress.
- `done` out 1: table completed; held until next accepted `start`.

## Operation
- Reset values: `sioc`=1, `siod_out`=1, `siod_oe`=1, `rom_addr`=0, `busy`=0, `done`=0, FSM=IDLE, quarter counter=0.
- States: IDLE, FETCH, DECODE, START, BITS, STOP, GAP, WAIT, FINISH.
- IDLE: on `start`, set `rom_addr`=0, `busy`=1, `done`=0, go to FETCH. `start` is ignored in every other state.
- FETCH: wait 1 cycle for `rom_data`.
- DECODE:
  - Entry 16'hFFFF → FINISH.
  - Entry 16'hFFF0 → WAIT (macro builds only).
  - Otherwise load the 27-bit shift register {DEVICE_ID,1'b0, reg,1'b0, value,1'b0}, go to START.
- START, 2 quarters: q0 `siod_out`=0, `sioc`=1; q1 `sioc`=0.
- BITS, 27 bits × 4 quarters, MSB first:
  - q0: `sioc`=0; present bit.
  - q1, q2: `sioc`=1.
  - q3: `sioc`=0.
  - Bits 9, 18, 27 are don't-care slots: `siod_oe`=0 for all 4 quarters. Otherwise `siod_oe`=1.
  - ACK is not checked.
- STOP, 3 quarters: q0 `siod_out`=0, `siod_oe`=1, `sioc`=0; q1 `sioc`=1; q2 `siod_out`=1.
- GAP, 8 quarters: bus idle high. Then `rom_addr`+1 and go to FETCH.
- `rom_addr` wraps 255→0 with no terminator detection. The table must contain 16'hFFFF.
- FINISH: bus idle, `busy`=0, `done`=1, go to IDLE.
- Async reset at any point, including mid-bit: outputs return to reset values immediately. The camera may see an aborted transfer; software re-issues `start`.

## Timing
- Quarter tick every DIV cycles. Counter runs only in START/BITS/STOP/GAP and clears on every state entry.
- Each phase lasts exactly DIV cycles.
- One write = 121 quarters (2+108+3+8) = 121·DIV cycles, plus 2 cycles FETCH/DECODE.
- `start` → first SIOD fall: 3 cycles.
- Terminator fetch → `done`=1: 3 cycles after `rom_addr` update.
- SIOD changes only while `sioc`=0, except START q0 and STOP q2.

## Configuration
- Macro: `SCCB_CFG_DELAY_EN`.
- Defined: entry 16'hFFF0 enters WAIT.
  - Bus held idle for exactly DELAY_CYCLES cycles, then `rom_addr`+1 → FETCH.
  - Used after a COM7 soft reset.
- Undefined:
  - WAIT state and its counter are not built.
  - 16'hFFF0 is written as reg 0xFF, value 0xF0.

## Test plan
All scenarios use DIV=2 and a 1-cycle ROM model.
- Reset: assert `rst_n`=0 → `sioc`=1, `siod_out`=1, `siod_oe`=1, `busy`=0, `done`=0, `rom_addr`=0.
- Table {16'h1280, 16'hFFFF}, pulse `start`:
  - Bits sampled at `sioc` rise are 0x42, 0x12, 0x80, with `siod_oe`=0 in slots 9/18/27.
  - `rom_addr` sequence 0, 1.
  - `done`=1 and `busy`=0 at 242+5 cycles.
- Table {16'hFFFF}, pulse `start`: no `sioc` toggle; `done`=1 within 3 cycles.
- Macro defined, DELAY_CYCLES=100, table {16'hFFF0, 16'h1100, 16'hFFFF}: bus idle for exactly 100 cycles, then write 0x42/0x11/0x00.
- Same table with macro undefined: write 0x42/0xFF/0xF0 first.
- `start` pulsed mid-transfer is ignored, with the bitstream unchanged. `start` after `done` clears `done` and restarts at `rom_addr`=0.
- `rst_n` low during BITS q1 → same-cycle idle outputs. Next `start` begins again at entry 0.
